// File: rtl/nf10_id_probe_pkg.sv
// Shared definitions for the identifier probe: AXI read response codes and
// the scan state machine encoding.
package nf10_id_probe_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/nf10_id_probe.sv
// Identifier probe: a read-only AXI4-Lite master that walks the identifier
// slave once after reset (and again on each rescan pulse), caches the words,
// and checks word 0 against the expected magic. One read in flight at a time.
module nf10_id_probe
  import nf10_id_probe_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_ID_BASEADDR      = '0,
  parameter int                            C_NUM_WORDS        = 16,
  parameter logic [31:0]                   C_EXPECT_WORD0     = 32'h0000DA01,
  parameter int                            C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic                          rescan,
  input  logic [3:0]                    word_sel,
  output logic [31:0]                   word_data,
  output logic                          busy,
  output logic                          done,
  output logic                          id_match,
  output logic                          resp_err,
  output logic                          timeout
);

  localparam int         AW   = C_M_AXI_ADDR_WIDTH;
  localparam int         TW   = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM = TW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST = 4'(C_NUM_WORDS - 1);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          rerr_q, rerr_d;
  logic          tout_q, tout_d;
  logic          auto_q;
  logic          cache_we;
  logic [31:0]   cache_wd;
  logic [31:0]   cache_q [C_NUM_WORDS];
  logic [31:0]   rd_d, rd_q;

  // Handshake outputs decode straight from state so reset drops them at once.
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_DATA);
  assign M_AXI_ARADDR  = C_ID_BASEADDR + AW'({idx_q, 2'b00});

  assign busy      = busy_q;
  assign done      = done_q;
  assign id_match  = match_q;
  assign resp_err  = rerr_q;
  assign timeout   = tout_q;
  assign word_data = rd_q;

  // Next-state and datapath decisions for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    match_d  = match_q;
    rerr_d   = rerr_q;
    tout_d   = tout_q;
    cache_we = 1'b0;
    cache_wd = '0;
    case (state_q)
      ST_IDLE: begin
        // The first cycle after reset acts as an implicit rescan.
        if (rescan || auto_q) begin
          state_d = ST_ADDR;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          rerr_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else if (cnt_q == TLIM) begin
          // Flag only; keep ARVALID up so a slow slave can still answer.
          tout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (M_AXI_RVALID) begin
          cache_we = 1'b1;
          cache_wd = (M_AXI_RRESP == RESP_OKAY) ? M_AXI_RDATA[31:0] : 32'h0;
          if (M_AXI_RRESP != RESP_OKAY) rerr_d = 1'b1;
          cnt_d = '0;
          if (idx_q == LAST) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ADDR;
          end
        end else if (cnt_q == TLIM) begin
          tout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_FIN: begin
        // Word 0 is already in the cache here, even for single-word scans.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        match_d = (cache_q[0] == C_EXPECT_WORD0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cached word readout; out-of-range selects read as zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < C_NUM_WORDS; i++)
      if (word_sel == 4'(i)) rd_d = cache_q[i];
  end

  // State and status registers.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      rerr_q  <= 1'b0;
      tout_q  <= 1'b0;
      auto_q  <= 1'b1;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      rerr_q  <= rerr_d;
      tout_q  <= tout_d;
      auto_q  <= 1'b0;
      rd_q    <= rd_d;
    end
  end

  // Identifier cache, written once per accepted read beat.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      for (int i = 0; i < C_NUM_WORDS; i++) cache_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_WORDS; i++)
        if (cache_we && idx_q == 4'(i)) cache_q[i] <= cache_wd;
    end
  end

endmodule

// File: tb/tb_nf10_id_probe.sv
// Bench for nf10_id_probe: a scripted AXI4-Lite slave with per-word wait
// states and responses, and a scan-level reference model (expected cache,
// flags and busy duration) derived from the slave's tables.
module tb_nf10_id_probe;
  import nf10_id_probe_pkg::*;

  localparam int          N     = 16;
  localparam int          TO    = 1024;
  localparam logic [31:0] BASE  = 32'h4000_0100;
  localparam logic [31:0] MAGIC = 32'h0000DA01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        rescan;
  logic [3:0]  word_sel;
  logic [31:0] word_data;
  logic        busy, done, id_match, resp_err, timeout;

  always #5 clk = ~clk;

  nf10_id_probe #(
    .C_ID_BASEADDR(BASE), .C_NUM_WORDS(N), .C_EXPECT_WORD0(MAGIC), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .rescan(rescan), .word_sel(word_sel), .word_data(word_data),
    .busy(busy), .done(done), .id_match(id_match), .resp_err(resp_err), .timeout(timeout)
  );

  // slave tables: data, response and wait states per word index
  logic [31:0] mem [N];
  logic [1:0]  rsp [N];
  int          arw [N];
  int          rw  [N];

  int errs = 0, checks = 0;
  int bcnt = 0, excl_viol = 0, addr_bad = 0, beat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus monitor: busy duration and AR/R exclusivity
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) bcnt++;
    if (ARVALID === 1'b1 && RREADY === 1'b1) excl_viol++;
  end

  // scripted slave, decisions made on the falling edge
  initial begin
    bit          ph;
    int          arc, rc, k;
    logic [31:0] cap;
    ph = 0; arc = 0; rc = 0; cap = '0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ARREADY = 0; RVALID = 0; ph = 0; arc = 0; rc = 0; beat = 0;
      end else begin
        k = beat % N;
        if (ph && RVALID) begin
          RVALID = 0; ph = 0; beat++; k = beat % N;
        end
        if (!ph) begin
          if (ARREADY) begin
            ARREADY = 0; ph = 1; rc = 0; arc = 0;
          end else if (ARVALID) begin
            if (arc == 0) begin
              cap = ARADDR;
              if (ARADDR !== BASE + 32'(4 * beat)) addr_bad++;
            end else if (ARADDR !== cap) addr_bad++;
            if (arc >= arw[k]) ARREADY = 1; else arc++;
          end
        end
        if (ph && !RVALID) begin
          if (rc >= rw[k]) begin
            RVALID = 1; RDATA = mem[k]; RRESP = rsp[k];
          end else rc++;
        end
      end
    end
  end

  task automatic fill(input bit with_err, input int maxw);
    for (int i = 0; i < N; i++) begin
      mem[i] = $urandom;
      rsp[i] = (with_err && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      arw[i] = $urandom_range(0, maxw);
      rw[i]  = $urandom_range(0, maxw);
    end
  endtask

  task automatic start_scan();
    @(negedge clk);
    beat = 0; bcnt = 0; rescan = 1;
    @(negedge clk);
    rescan = 0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_flags", {id_match, resp_err, timeout}, 0);
  endtask

  // wait for completion, then compare against the scan-level model
  task automatic finish_scan(input string nm);
    logic [31:0] ec [N];
    bit er, et;
    int dur, n;
    n = 0;
    while (!(done === 1'b1 && busy === 1'b0) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk({nm, "_done"}, done, 1);
    er = 0; et = 0; dur = 1;
    for (int i = 0; i < N; i++) begin
      ec[i] = (rsp[i] == RESP_OKAY) ? mem[i] : 32'h0;
      if (rsp[i] != RESP_OKAY) er = 1;
      if (arw[i] >= TO || rw[i] >= TO) et = 1;
      dur += 2 + arw[i] + rw[i];
    end
    chk({nm, "_cycles"}, 64'(bcnt), 64'(dur));
    chk({nm, "_match"}, id_match, (ec[0] == MAGIC));
    chk({nm, "_rerr"}, resp_err, er);
    chk({nm, "_tout"}, timeout, et);
    chk({nm, "_araddr"}, 64'(addr_bad), 0);
    for (int i = 0; i < N; i++) begin
      word_sel = 4'(i);
      @(negedge clk);
      chk($sformatf("%s_word%0d", nm, i), word_data, ec[i]);
    end
  endtask

  initial begin
    int n;
    rescan = 0; word_sel = 4'd15;
    fill(0, 0);
    mem[0] = MAGIC; mem[15] = mem[15] | 32'h1;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_status", {busy, done, id_match, resp_err, timeout}, 0);
    chk("rst_word", word_data, 0);
    bcnt = 0; rst_n = 1;
    @(negedge clk);
    chk("auto_busy", busy, 1);
    @(negedge clk);
    chk("cache_rst", word_data, 0);
    finish_scan("boot");

    // wrong magic
    mem[0] = 32'h12345678;
    start_scan(); finish_scan("badid");

    // slave error on word 5
    mem[0] = MAGIC; rsp[5] = RESP_SLVERR;
    start_scan(); finish_scan("slverr");

    // ARREADY stalled 1100 cycles on word 2
    rsp[5] = RESP_OKAY; arw[2] = 1100;
    start_scan();
    n = 0;
    while (!(ARVALID === 1'b1 && ARADDR === BASE + 32'd8) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("stall_seen", (n < 100), 1);
    repeat (1000) @(negedge clk);
    chk("tout_early", timeout, 0);
    repeat (30) @(negedge clk);
    chk("tout_set", timeout, 1);
    chk("stall_addr", {ARVALID, ARADDR}, {1'b1, BASE + 32'd8});
    finish_scan("stall");

    // rescan while busy is ignored
    arw[2] = 0;
    fill(0, 2);
    start_scan();
    repeat (5) @(negedge clk);
    rescan = 1; @(negedge clk); rescan = 0;
    finish_scan("busyrescan");

    // reset in the data phase of word 7
    fill(0, 1);
    start_scan();
    n = 0;
    while (!(RREADY === 1'b1 && ARADDR === BASE + 32'd28) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("rst7_seen", (n < 200), 1);
    rst_n = 0;
    #1;
    chk("rst7_drop", {ARVALID, RREADY, busy}, 0);
    repeat (3) @(negedge clk);
    bcnt = 0; rst_n = 1;
    finish_scan("rst7");

    // randomized scans with errors and wait states
    for (int t = 0; t < 5; t++) begin
      fill(1, 3);
      if ($urandom_range(0, 1) == 1) mem[0] = MAGIC;
      start_scan();
      finish_scan($sformatf("rnd%0d", t));
    end

    chk("excl", 64'(excl_viol), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
